// File: rtl/cpu_snoop_write_queue_pkg.sv
// Shared types and constants for the SE-VGA CPU snoop write path.
package sevga_pkg;

  localparam logic [13:0] FB_OFF_LO = 14'h1380;
  localparam logic [13:0] FB_OFF_HI = 14'h3E3F;
  localparam logic [4:0]  VIA_HI    = 5'h1D;
  localparam logic [4:0]  VIA_MID   = 5'h1F;

  typedef struct packed {
    logic        bufSel;
    logic [13:0] offset;
    logic [15:0] data;
    logic [1:0]  ben;
  } snoop_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } drain_state_t;

endpackage

// File: rtl/cpu_snoop_write_queue_fifo.sv
// DEPTH-entry synchronous FIFO of captured framebuffer writes; exposes head and
// the entry behind it so the drain can chain entries without a bubble.
module snoop_fifo
  import sevga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     pixClk,
  input  logic                     nReset,
  input  logic                     push,
  input  snoop_entry_t             pushData,
  input  logic                     pop,
  output snoop_entry_t             headData,
  output snoop_entry_t             nextData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  snoop_entry_t   mem [DEPTH];
  logic [AW:0]    wrPtr;
  logic [AW:0]    rdPtr;
  logic           doPush;
  logic           doPop;

  assign level    = wrPtr - rdPtr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign doPop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr[AW-1:0]];
  assign nextData = mem[rdPtr[AW-1:0] + AW'(1)];

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge pixClk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/cpu_snoop_write_queue.sv
// Snoops 68000 writes to the Mac SE framebuffers and replays them as VRAM byte
// writes. Optional VIA buffer-select tracking under `VIA_BUFSEL_EN.
module cpu_snoop_write_queue
  import sevga_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     pixClk,
  input  logic                     nReset,
  input  logic [23:1]              cpuAddr,
  input  logic [15:0]              cpuData,
  input  logic                     ncpuAS,
  input  logic                     ncpuUDS,
  input  logic                     ncpuLDS,
  input  logic                     cpuRnW,
  input  logic [2:0]               ramSize,
  output logic                     wrValid,
  input  logic                     wrReady,
  output logic [14:0]              wrAddr,
  output logic [7:0]               wrData,
  output logic                     wrLane,
  output logic [$clog2(DEPTH):0]   fifoLevel,
  output logic                     overflow,
  output logic                     vidBufSel
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] asSync, udsSync, ldsSync, rnwSync;
  logic asS, udsS, ldsS, rnwS;
  logic armed, capture, fbHit, push, pop, loadNow, full, empty;
  snoop_entry_t pushEntry, head, nextE, ld;
  drain_state_t state;

  assign asS  = asSync[SYNC_STAGES-1];
  assign udsS = udsSync[SYNC_STAGES-1];
  assign ldsS = ldsSync[SYNC_STAGES-1];
  assign rnwS = rnwSync[SYNC_STAGES-1];

  // AS chain resets to "asserted" so a cycle in flight at reset release is never armed.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      asSync  <= '0;
      udsSync <= '1;
      ldsSync <= '1;
      rnwSync <= '1;
      armed   <= 1'b0;
    end else begin
      asSync  <= {asSync[SYNC_STAGES-2:0],  ncpuAS};
      udsSync <= {udsSync[SYNC_STAGES-2:0], ncpuUDS};
      ldsSync <= {ldsSync[SYNC_STAGES-2:0], ncpuLDS};
      rnwSync <= {rnwSync[SYNC_STAGES-2:0], cpuRnW};
      if (asS)          armed <= 1'b1;
      else if (capture) armed <= 1'b0;
    end
  end

  assign capture = armed && !asS && !rnwS && (!udsS || !ldsS);
  assign fbHit   = (cpuAddr[23:22] == 2'b00) && (cpuAddr[21:19] == ramSize) &&
                   (cpuAddr[18:16] == 3'b111) &&
                   (cpuAddr[14:1] >= FB_OFF_LO) && (cpuAddr[14:1] <= FB_OFF_HI);
  assign push    = capture && fbHit;

  // Buffer bit follows A15: 1 = main buffer, 0 = alt buffer.
  assign pushEntry = '{bufSel: cpuAddr[15], offset: cpuAddr[14:1] - FB_OFF_LO,
                       data: cpuData, ben: {~udsS, ~ldsS}};

  snoop_fifo #(.DEPTH(DEPTH)) uFifo (
    .pixClk   (pixClk),
    .nReset   (nReset),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .headData (head),
    .nextData (nextE),
    .full     (full),
    .empty    (empty),
    .level    (fifoLevel)
  );

  assign pop     = wrReady && (((state == HI) && !head.ben[0]) || (state == LO));
  // Popping with another entry queued loads it directly, folding the NEXT step into the pop.
  assign loadNow = ((state == IDLE) && !empty) || (pop && (fifoLevel > LW'(1)));
  assign ld      = (state == IDLE) ? head : nextE;

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      wrValid  <= 1'b0;
      wrAddr   <= '0;
      wrData   <= '0;
      wrLane   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      if (loadNow) begin
        wrValid <= 1'b1;
        wrAddr  <= {ld.bufSel, ld.offset};
        if (ld.ben[1]) begin
          state  <= HI;
          wrLane <= 1'b0;
          wrData <= ld.data[15:8];
        end else begin
          state  <= LO;
          wrLane <= 1'b1;
          wrData <= ld.data[7:0];
        end
      end else if ((state == HI) && wrReady && head.ben[0]) begin
        state  <= LO;
        wrLane <= 1'b1;
        wrData <= head.data[7:0];
      end else if (pop) begin
        state   <= IDLE;
        wrValid <= 1'b0;
      end
    end
  end

`ifdef VIA_BUFSEL_EN
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      vidBufSel <= 1'b0;
    end else if (capture && (cpuAddr[23:19] == VIA_HI) &&
                 (cpuAddr[12:8] == VIA_MID) && !udsS) begin
      vidBufSel <= ~cpuData[14];
    end
  end
`else
  assign vidBufSel = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_snoop_write_queue.sv
// Directed bench for cpu_snoop_write_queue (DEPTH=4, SYNC_STAGES=2).
module tb_cpu_snoop_write_queue;

  logic        pixClk = 1'b0;
  logic        nReset;
  logic [23:1] cpuAddr;
  logic [15:0] cpuData;
  logic        ncpuAS, ncpuUDS, ncpuLDS, cpuRnW;
  logic [2:0]  ramSize;
  logic        wrValid, wrReady, wrLane, overflow, vidBufSel;
  logic [14:0] wrAddr;
  logic [7:0]  wrData;
  logic [2:0]  fifoLevel;

  int nCmp = 0;
  int nErr = 0;

  cpu_snoop_write_queue #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .pixClk    (pixClk),
    .nReset    (nReset),
    .cpuAddr   (cpuAddr),
    .cpuData   (cpuData),
    .ncpuAS    (ncpuAS),
    .ncpuUDS   (ncpuUDS),
    .ncpuLDS   (ncpuLDS),
    .cpuRnW    (cpuRnW),
    .ramSize   (ramSize),
    .wrValid   (wrValid),
    .wrReady   (wrReady),
    .wrAddr    (wrAddr),
    .wrData    (wrData),
    .wrLane    (wrLane),
    .fifoLevel (fifoLevel),
    .overflow  (overflow),
    .vidBufSel (vidBufSel)
  );

  always #5 pixClk = ~pixClk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pixClk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input logic [23:0] byteAddr, input logic [15:0] data,
                         input logic uds, input logic lds, input logic rnw);
    cpuAddr = byteAddr[23:1];
    cpuData = data;
    cpuRnW  = rnw;
    ncpuAS  = 1'b0;
    ncpuUDS = ~uds;
    ncpuLDS = ~lds;
  endtask

  task automatic release_bus();
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
  endtask

  task automatic busCycle(input logic [23:0] byteAddr, input logic [15:0] data,
                          input logic uds, input logic lds, input logic rnw);
    strobes(byteAddr, data, uds, lds, rnw);
    step(5);
    release_bus();
    step(3);
  endtask

  initial begin
    nReset  = 1'b0;
    cpuAddr = '0;
    cpuData = '0;
    release_bus();
    ramSize = 3'd3;
    wrReady = 1'b0;
    step(3);
    check("rst_wrValid", wrValid, 0);
    check("rst_wrAddr", wrAddr, 0);
    check("rst_wrData", wrData, 0);
    check("rst_wrLane", wrLane, 0);
    check("rst_level", fifoLevel, 0);
    check("rst_overflow", overflow, 0);
    check("rst_vidBufSel", vidBufSel, 0);
    nReset = 1'b1;
    step(4);

    // Word write to main buffer, with capture latency
    strobes(24'h1FA700, 16'hA55A, 1'b1, 1'b1, 1'b0);
    step(2);
    check("lat_level_early", fifoLevel, 0);
    step(1);
    check("lat_level_push", fifoLevel, 1);
    step(2);
    release_bus();
    step(3);
    check("w1_valid", wrValid, 1);
    check("w1_hi_addr", wrAddr, 15'h4000);
    check("w1_hi_lane", wrLane, 0);
    check("w1_hi_data", wrData, 8'hA5);
    step(2);
    check("w1_hold_data", wrData, 8'hA5);
    check("w1_hold_valid", wrValid, 1);
    wrReady = 1'b1;
    step(1);
    check("w1_lo_valid", wrValid, 1);
    check("w1_lo_addr", wrAddr, 15'h4000);
    check("w1_lo_lane", wrLane, 1);
    check("w1_lo_data", wrData, 8'h5A);
    step(1);
    check("w1_done_valid", wrValid, 0);
    check("w1_done_level", fifoLevel, 0);
    wrReady = 1'b0;

    // LDS-only write to alt buffer
    busCycle(24'h1F2702, 16'h0033, 1'b0, 1'b1, 1'b0);
    check("w2_valid", wrValid, 1);
    check("w2_addr", wrAddr, 15'h0001);
    check("w2_lane", wrLane, 1);
    check("w2_data", wrData, 8'h33);
    wrReady = 1'b1;
    step(1);
    check("w2_done_valid", wrValid, 0);
    check("w2_done_level", fifoLevel, 0);
    wrReady = 1'b0;

    // Writes that must be ignored
    busCycle(24'h1FA6FE, 16'h1234, 1'b1, 1'b1, 1'b0);
    check("miss_low_valid", wrValid, 0);
    check("miss_low_level", fifoLevel, 0);
    busCycle(24'h1FA700, 16'h1234, 1'b1, 1'b1, 1'b1);
    check("miss_read_valid", wrValid, 0);
    check("miss_read_level", fifoLevel, 0);
    ramSize = 3'd2;
    busCycle(24'h1FA700, 16'h1234, 1'b1, 1'b1, 1'b0);
    check("miss_ram_valid", wrValid, 0);
    check("miss_ram_level", fifoLevel, 0);
    ramSize = 3'd3;

    // Five writes into a stalled four-entry queue
    for (int i = 0; i < 5; i++) begin
      busCycle(24'h1FA700 + 24'(2 * i), {8'(i + 1), 8'(8'h10 + i)}, 1'b1, 1'b1, 1'b0);
      if (i == 3) begin
        check("ovf_level4", fifoLevel, 4);
        check("ovf_not_yet", overflow, 0);
      end
    end
    check("ovf_level_full", fifoLevel, 4);
    check("ovf_flag", overflow, 1);
    wrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_hi_addr", i), wrAddr, 15'h4000 + i);
      check($sformatf("drain%0d_hi_lane", i), {wrValid, wrLane}, 2'b10);
      check($sformatf("drain%0d_hi_data", i), wrData, i + 1);
      step(1);
      check($sformatf("drain%0d_lo_lane", i), {wrValid, wrLane}, 2'b11);
      check($sformatf("drain%0d_lo_data", i), wrData, 8'h10 + i);
      step(1);
    end
    check("drain_end_valid", wrValid, 0);
    check("drain_end_level", fifoLevel, 0);
    check("drain_ovf_sticky", overflow, 1);
    wrReady = 1'b0;

    // Reset during a write cycle that outlives the reset
    strobes(24'h1FA700, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    step(1);
    nReset = 1'b0;
    #1;
    check("mid_rst_overflow", overflow, 0);
    step(2);
    nReset = 1'b1;
    step(4);
    check("rstw_level", fifoLevel, 0);
    check("rstw_valid", wrValid, 0);
    check("rstw_overflow", overflow, 0);
    check("rstw_addr", wrAddr, 0);
    release_bus();
    step(3);
    check("rstw_after_level", fifoLevel, 0);
    busCycle(24'h1FA702, 16'hC3D4, 1'b1, 1'b0, 1'b0);
    check("rstw_next_addr", wrAddr, 15'h4001);
    check("rstw_next_data", wrData, 8'hC3);
    wrReady = 1'b1;
    step(2);
    wrReady = 1'b0;

    // VIA buffer select
    busCycle(24'hEFFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
`ifdef VIA_BUFSEL_EN
    check("via_bit0", vidBufSel, 1);
`else
    check("via_off_0", vidBufSel, 0);
`endif
    check("via_level", fifoLevel, 0);
    busCycle(24'hEFFFFE, 16'h4000, 1'b1, 1'b0, 1'b0);
`ifdef VIA_BUFSEL_EN
    check("via_bit1", vidBufSel, 0);
`else
    check("via_off_1", vidBufSel, 0);
`endif
    check("via_valid", wrValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
